// File: rtl/prio_pending_encoder.sv
// Sticky pending-event register with a registered priority/round-robin grant port.
// One grant is presented at a time and held until the consumer accepts it.
module prio_pending_encoder #(
  parameter int N     = 8,
  parameter int W     = $clog2(N),
  parameter int RR_EN = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic [N-1:0] mask,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         overflow
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_e         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [W-1:0]   out_idx_q, out_idx_d;
  logic [W-1:0]   last_q, last_d;
  logic           overflow_q, overflow_d;

  logic [N-1:0]   clr;
  logic [N-1:0]   eligible;
  logic           found;
  logic [W-1:0]   sel_idx;

  // Only an accepted grant clears its pending bit; a fresh request the same cycle wins.
  assign clr      = (state_q == PRESENT && out_ready) ? (ONE << out_idx_q) : '0;
  assign eligible = pending_q & mask;

  // Descending search with wrap; fixed mode always starts at the top channel.
  always_comb begin
    int start;
    int j;
    logic [W-1:0] jj;
    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    start   = N - 1;
    j       = 0;
    jj      = '0;
    found   = 1'b0;
    sel_idx = '0;
    if (RR_EN != 0 && last_q != '0) start = int'(last_q) - 1;
    for (int k = 0; k < N; k++) begin
      j = start - k;
      if (j < 0) j = j + N;
      jj = W'(j);
      if (!found && eligible[jj]) begin
        found   = 1'b1;
        sel_idx = jj;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    out_idx_d  = out_idx_q;
    last_d     = last_q;
    pending_d  = (pending_q & ~clr) | req_in;
    overflow_d = |(req_in & pending_q & ~clr);
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = PRESENT;
          out_idx_d = sel_idx;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          state_d = IDLE;
          last_d  = out_idx_q;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      out_idx_q  <= '0;
      last_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      out_idx_q  <= out_idx_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = (state_q == PRESENT);
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_prio_pending_encoder.sv
// Directed bench: a fixed-priority and a round-robin instance share the same stimulus;
// outputs are sampled on the falling edge after each rising edge.
module tb_prio_pending_encoder;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_in;
  logic [N-1:0] mask;
  logic         out_ready;

  logic         f_valid, r_valid;
  logic [W-1:0] f_idx, r_idx;
  logic [N-1:0] f_pend, r_pend;
  logic         f_ovf, r_ovf;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  prio_pending_encoder #(.N(N), .RR_EN(0)) dut_fixed (
    .clk(clk), .rst(rst), .req_in(req_in), .mask(mask), .out_ready(out_ready),
    .out_valid(f_valid), .out_idx(f_idx), .pending(f_pend), .overflow(f_ovf)
  );

  prio_pending_encoder #(.N(N), .RR_EN(1)) dut_rr (
    .clk(clk), .rst(rst), .req_in(req_in), .mask(mask), .out_ready(out_ready),
    .out_valid(r_valid), .out_idx(r_idx), .pending(r_pend), .overflow(r_ovf)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  int rr_exp [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

  initial begin
    rst = 1'b1; req_in = '0; mask = 8'hFF; out_ready = 1'b0;
    tick(); tick();
    check("rst_valid",    f_valid, 0);
    check("rst_idx",      f_idx,   0);
    check("rst_pending",  f_pend,  0);
    check("rst_overflow", f_ovf,   0);

    // Fixed priority: two simultaneous events drain highest first.
    rst = 1'b0; req_in = 8'b0010_0100; out_ready = 1'b1;
    tick();
    check("fix_pend_set",  f_pend,  8'h24);
    check("fix_t1_valid",  f_valid, 0);
    req_in = '0;
    tick();
    check("fix_t2_valid",  f_valid, 1);
    check("fix_t2_idx",    f_idx,   5);
    tick();
    check("fix_acc5_valid", f_valid, 0);
    check("fix_acc5_pend",  f_pend,  8'h04);
    tick();
    check("fix_g2_valid",  f_valid, 1);
    check("fix_g2_idx",    f_idx,   2);
    tick();
    check("fix_end_valid", f_valid, 0);
    check("fix_end_pend",  f_pend,  0);
    tick();
    check("fix_idle_valid", f_valid, 0);

    // Backpressure: index 3 held while channel 7 arrives and the mask drops.
    out_ready = 1'b0; req_in = 8'h08;
    tick();
    req_in = '0;
    tick();
    check("bp_valid", f_valid, 1);
    check("bp_idx",   f_idx,   3);
    req_in = 8'h80;
    tick();
    check("bp_hold1_idx", f_idx, 3);
    req_in = '0; mask = 8'h00;
    tick();
    check("bp_hold2_idx", f_idx, 3);
    check("bp_hold2_valid", f_valid, 1);
    mask = 8'hFF;
    tick(); tick(); tick();
    check("bp_hold5_idx",   f_idx,   3);
    check("bp_hold5_valid", f_valid, 1);
    check("bp_hold5_pend",  f_pend,  8'h88);
    out_ready = 1'b1;
    tick();
    check("bp_acc_valid", f_valid, 0);
    check("bp_acc_pend",  f_pend,  8'h80);
    tick();
    check("bp_next_idx",   f_idx,   7);
    check("bp_next_valid", f_valid, 1);
    tick();
    check("bp_drain_pend", f_pend, 0);
    out_ready = 1'b0;

    // Collision: second pulse on a pending channel, then set-wins at acceptance.
    req_in = 8'h10;
    tick();
    check("col_first_ovf", f_ovf, 0);
    req_in = '0;
    tick();
    check("col_present_idx", f_idx, 4);
    req_in = 8'h10;
    tick();
    check("col_ovf_hi", f_ovf, 1);
    req_in = '0;
    tick();
    check("col_ovf_lo", f_ovf, 0);
    out_ready = 1'b1; req_in = 8'h10;
    tick();
    check("col_setwin_pend",  f_pend,  8'h10);
    check("col_setwin_ovf",   f_ovf,   0);
    check("col_setwin_valid", f_valid, 0);
    req_in = '0;
    tick();
    check("col_regrant_idx", f_idx,   4);
    check("col_regrant_ovf", f_ovf,   0);
    tick();
    check("col_drain_pend", f_pend, 0);
    out_ready = 1'b0;

    // Mask: channel 7 stays pending until it becomes eligible.
    mask = 8'h01; req_in = 8'h81;
    tick();
    req_in = '0;
    tick();
    check("msk_idx0",   f_idx,   0);
    check("msk_valid0", f_valid, 1);
    out_ready = 1'b1;
    tick();
    check("msk_pend80", f_pend, 8'h80);
    tick(); tick();
    check("msk_blocked_valid", f_valid, 0);
    check("msk_blocked_pend",  f_pend,  8'h80);
    mask = 8'hFF;
    tick();
    check("msk_open_idx",   f_idx,   7);
    check("msk_open_valid", f_valid, 1);
    tick();
    out_ready = 1'b0;

    // Reset while a grant is presented with ready asserted.
    req_in = 8'h04;
    tick();
    req_in = '0;
    tick();
    check("rmg_pre_idx", f_idx, 2);
    rst = 1'b1; out_ready = 1'b1; req_in = 8'h20;
    tick();
    check("rmg_valid",   f_valid, 0);
    check("rmg_idx",     f_idx,   0);
    check("rmg_pending", f_pend,  0);
    check("rmg_ovf",     f_ovf,   0);
    check("rmg_rr_pend", r_pend,  0);
    rst = 1'b0; out_ready = 1'b0; req_in = '0;
    tick();
    check("rmg_after_valid", f_valid, 0);

    // Round robin with every channel kept pending.
    req_in = 8'hFF;
    tick();
    for (int g = 0; g < 9; g++) begin
      req_in = '0; out_ready = 1'b0;
      tick();
      check($sformatf("rr_valid_%0d", g), r_valid, 1);
      check($sformatf("rr_idx_%0d", g),   r_idx,   rr_exp[g]);
      check($sformatf("rr_fix_idx_%0d", g), f_idx, 7);
      req_in = 8'hFF; out_ready = 1'b1;
      tick();
      check($sformatf("rr_pend_%0d", g), r_pend, 8'hFF);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
